lot_occupancy_tracker: RTL and testbench

Multi-gate parking-lot occupancy tracker: the parametrised successor of the single-gate lot counter. It samples level-type vehicle sensors on GATES entry lanes and GATES exit lanes, and synchronises and edge-detects each one. It sums all arrivals and departures of a cycle into one saturating occupancy update, and drives status for the lot sign and barrier logic: count, free spaces, full/empty/near-full, and sticky overflow/underflow errors.

---
 rtl/lot_occupancy_tracker.sv | 200 ++++++++++++++++++++
 tb/tb_lot_occupancy_tracker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lot_occupancy_tracker.sv
// -----------------------------------------------------------------------------
// lot_occupancy_tracker
//
// Multi-gate parking-lot occupancy tracker. Each entry and exit lane carries a
// level-type vehicle sensor. Every sensor is synchronised (two flops), then
// compared against a history flop so that one low-to-high transition yields
// one single-cycle event pulse. All entry and exit pulses of a cycle are summed
// into one saturating update of the occupancy count.
//
// Parameters
//   GATES     number of entry lanes and number of exit lanes (1..8)
//   CAPACITY  lot capacity in spaces (1..255)
//   INIT      occupancy loaded at reset and on preset (0..CAPACITY)
//   MARGIN    near_full asserts when free <= MARGIN
//   WIDTH     width of count/free, 2^WIDTH > CAPACITY
//
// Ports
//   clk        in   rising-edge clock for all state
//   reset_n    in   asynchronous active-low reset
//   enter      in   [GATES] entry sensor levels (asynchronous)
//   exit       in   [GATES] exit sensor levels (asynchronous)
//   preset     in   load INIT into count, discarding this cycle's events
//   clear_err  in   clear the sticky overflow/underflow flags
//   count      out  [WIDTH] current occupancy
//   free       out  [WIDTH] CAPACITY - count
//   full       out  count == CAPACITY
//   empty      out  count == 0
//   near_full  out  free <= MARGIN
//   overflow   out  sticky: an update was clipped at CAPACITY
//   underflow  out  sticky: an update was clipped at 0
// -----------------------------------------------------------------------------
module lot_occupancy_tracker #(
    parameter int GATES    = 2,
    parameter int CAPACITY = 20,
    parameter int INIT     = 0,
    parameter int MARGIN   = 2,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [GATES-1:0] enter,
    input  logic [GATES-1:0] exit,
    input  logic             preset,
    input  logic             clear_err,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] free,
    output logic             full,
    output logic             empty,
    output logic             near_full,
    output logic             overflow,
    output logic             underflow
);

    // Width of a per-cycle event count (0..GATES).
    localparam int CNT_W = $clog2(GATES + 1);
    // Signed width for count + E - X: holds count + GATES and -GATES without wrap.
    localparam int RAW_W = WIDTH + CNT_W + 2;

    localparam logic [WIDTH-1:0]        CAP_W    = WIDTH'(CAPACITY);
    localparam logic [WIDTH-1:0]        INIT_W   = WIDTH'(INIT);
    localparam logic [WIDTH-1:0]        MARGIN_W = WIDTH'(MARGIN);
    localparam logic [WIDTH-1:0]        FREE_RST = WIDTH'(CAPACITY - INIT);
    localparam logic                    FULL_RST = (INIT == CAPACITY);
    localparam logic                    EMPTY_RST = (INIT == 0);
    localparam logic                    NEAR_RST = ((CAPACITY - INIT) <= MARGIN);
    localparam logic signed [RAW_W-1:0] CAP_S    = RAW_W'(CAPACITY);

    // ------------------------------------------------------------------
    // Sensor synchronisers and history flops.
    // Everything resets to 1 so a sensor already high at reset release
    // must go low and high again before it counts.
    // ------------------------------------------------------------------
    logic [GATES-1:0] enter_s1_reg, enter_s2_reg, enter_s3_reg;
    logic [GATES-1:0] exit_s1_reg, exit_s2_reg, exit_s3_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enter_s1_reg <= '1;
            enter_s2_reg <= '1;
            enter_s3_reg <= '1;
            exit_s1_reg  <= '1;
            exit_s2_reg  <= '1;
            exit_s3_reg  <= '1;
        end else begin
            // History keeps advancing even on preset cycles.
            enter_s1_reg <= enter;
            enter_s2_reg <= enter_s1_reg;
            enter_s3_reg <= enter_s2_reg;
            exit_s1_reg  <= exit;
            exit_s2_reg  <= exit_s1_reg;
            exit_s3_reg  <= exit_s2_reg;
        end
    end

    // Per-lane rising-edge pulses.
    logic [GATES-1:0] enter_pulse;
    logic [GATES-1:0] exit_pulse;

    genvar gi;
    generate
        for (gi = 0; gi < GATES; gi++) begin : g_lane
            assign enter_pulse[gi] = enter_s2_reg[gi] & ~enter_s3_reg[gi];
            assign exit_pulse[gi]  = exit_s2_reg[gi]  & ~exit_s3_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Popcount of pulses across all lanes.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] enter_cnt;
    logic [CNT_W-1:0] exit_cnt;

    always_comb begin
        enter_cnt = '0;
        exit_cnt  = '0;
        for (int i = 0; i < GATES; i++) begin
            enter_cnt = enter_cnt + CNT_W'(enter_pulse[i]);
            exit_cnt  = exit_cnt  + CNT_W'(exit_pulse[i]);
        end
    end

    // ------------------------------------------------------------------
    // Occupancy state.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] free_reg, free_next;
    logic             full_reg, full_next;
    logic             empty_reg, empty_next;
    logic             near_full_reg, near_full_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;

    logic signed [RAW_W-1:0] raw;

    // Enter and exit net out in one signed sum before any clipping, so
    // simultaneous arrivals and departures never produce a spurious error.
    assign raw = $signed({{(RAW_W-WIDTH){1'b0}}, count_reg})
               + $signed({{(RAW_W-CNT_W){1'b0}}, enter_cnt})
               - $signed({{(RAW_W-CNT_W){1'b0}}, exit_cnt});

    always_comb begin
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        // Clear first, so an error detected in the same cycle still sets.
        if (clear_err) begin
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end

        if (preset) begin
            // Events this cycle are dropped; flags are left alone.
            count_next = INIT_W;
        end else if (raw[RAW_W-1]) begin
            count_next     = '0;
            underflow_next = 1'b1;
        end else if (raw > CAP_S) begin
            count_next    = CAP_W;
            overflow_next = 1'b1;
        end else begin
            count_next = raw[WIDTH-1:0];
        end

        // Status is derived from the next count so it lines up with count.
        free_next      = CAP_W - count_next;
        full_next      = (count_next == CAP_W);
        empty_next     = (count_next == '0);
        near_full_next = (free_next <= MARGIN_W);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg     <= INIT_W;
            free_reg      <= FREE_RST;
            full_reg      <= FULL_RST;
            empty_reg     <= EMPTY_RST;
            near_full_reg <= NEAR_RST;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            free_reg      <= free_next;
            full_reg      <= full_next;
            empty_reg     <= empty_next;
            near_full_reg <= near_full_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign count     = count_reg;
    assign free      = free_reg;
    assign full      = full_reg;
    assign empty     = empty_reg;
    assign near_full = near_full_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_lot_occupancy_tracker.sv
// -----------------------------------------------------------------------------
// tb_lot_occupancy_tracker
//
// Directed stimulus for lot_occupancy_tracker (GATES=2, CAPACITY=20, INIT=0,
// MARGIN=2). The stimulus process pushes a hand-computed expectation (count
// plus error flags) into a queue whenever the DUT outputs should be settled;
// a separate monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_lot_occupancy_tracker;

    localparam int G   = 2;
    localparam int CAP = 20;
    localparam int MRG = 2;
    localparam int W   = 8;

    logic         clk;
    logic         reset_n;
    logic [G-1:0] enter;
    logic [G-1:0] exit_s;
    logic         preset;
    logic         clear_err;
    logic [W-1:0] count;
    logic [W-1:0] free;
    logic         full;
    logic         empty;
    logic         near_full;
    logic         overflow;
    logic         underflow;

    lot_occupancy_tracker #(
        .GATES   (G),
        .CAPACITY(CAP),
        .INIT    (0),
        .MARGIN  (MRG),
        .WIDTH   (W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enter    (enter),
        .exit     (exit_s),
        .preset   (preset),
        .clear_err(clear_err),
        .count    (count),
        .free     (free),
        .full     (full),
        .empty    (empty),
        .near_full(near_full),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string    name;
        int       cnt;
        logic     ovf;
        logic     unf;
    } exp_t;

    exp_t q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    // Full expected output vector from a hand-given count and flags.
    function automatic logic [20:0] expect_vec(input int cnt, input logic ovf, input logic unf);
        int fr;
        fr = CAP - cnt;
        return {W'(cnt), W'(fr), (cnt == CAP), (cnt == 0), (fr <= MRG), ovf, unf};
    endfunction

    // Monitor: compares one expectation per falling edge when available.
    initial begin
        exp_t        e;
        logic [20:0] act;
        logic [20:0] req;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {count, free, full, empty, near_full, overflow, underflow};
                req = expect_vec(e.cnt, e.ovf, e.unf);
                n_compared++;
                if (act !== req) begin
                    n_mismatched++;
                    $display("FAIL %s: got count=%0d free=%0d full=%b empty=%b nf=%b ovf=%b unf=%b, want count=%0d free=%0d full=%b empty=%b nf=%b ovf=%b unf=%b",
                             e.name, act[20:13], act[12:5], act[4], act[3], act[2], act[1], act[0],
                             req[20:13], req[12:5], req[4], req[3], req[2], req[1], req[0]);
                end else begin
                    $display("check %s: count=%0d free=%0d ovf=%b unf=%b ok",
                             e.name, count, free, overflow, underflow);
                end
            end
        end
    end

    task automatic expect_state(input string name, input int cnt, input logic ovf, input logic unf);
        exp_t e;
        e.name = name;
        e.cnt  = cnt;
        e.ovf  = ovf;
        e.unf  = unf;
        q.push_back(e);
    endtask

    // One vehicle event: raise the selected lanes, hold for the update edge,
    // optionally assert clear_err/preset on exactly that edge, then lower and
    // let the lanes rest low. Entered and left at posedge+1.
    task automatic vehicle(input logic [G-1:0] en, input logic [G-1:0] ex,
                           input logic clr, input logic pre);
        enter  = enter | en;
        exit_s = exit_s | ex;
        @(posedge clk); #1;           // s1 captures
        @(posedge clk); #1;           // s2 high, pulse presented
        clear_err = clr;
        preset    = pre;
        @(posedge clk); #1;           // count updates here
        clear_err = 1'b0;
        preset    = 1'b0;
        enter     = enter & ~en;
        exit_s    = exit_s & ~ex;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Absolute bound on run time.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        enter     = 2'b01;        // held high through reset release
        exit_s    = 2'b00;
        preset    = 1'b0;
        clear_err = 1'b0;
        idle(3);
        expect_state("reset_values", 0, 1'b0, 1'b0);
        idle(2);
        reset_n = 1'b1;
        idle(5);
        expect_state("high_through_reset", 0, 1'b0, 1'b0);
        enter = 2'b00;
        idle(4);
        expect_state("release_low_no_count", 0, 1'b0, 1'b0);

        vehicle(2'b01, 2'b00, 1'b0, 1'b0);
        expect_state("single_enter", 1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) vehicle(2'b01, 2'b00, 1'b0, 1'b0);
        expect_state("sixteen", 16, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) vehicle(2'b01, 2'b00, 1'b0, 1'b0);
        expect_state("near_full_18", 18, 1'b0, 1'b0);
        vehicle(2'b01, 2'b00, 1'b0, 1'b0);
        expect_state("count_19", 19, 1'b0, 1'b0);

        vehicle(2'b11, 2'b00, 1'b0, 1'b0);
        expect_state("overflow_clip", 20, 1'b1, 1'b0);
        clear_err = 1'b1;
        idle(1);
        clear_err = 1'b0;
        expect_state("clear_overflow", 20, 1'b0, 1'b0);

        for (int i = 0; i < 7; i++) vehicle(2'b00, 2'b11, 1'b0, 1'b0);
        vehicle(2'b00, 2'b01, 1'b0, 1'b0);
        expect_state("down_to_5", 5, 1'b0, 1'b0);
        vehicle(2'b11, 2'b01, 1'b0, 1'b0);
        expect_state("two_in_one_out", 6, 1'b0, 1'b0);
        vehicle(2'b00, 2'b01, 1'b0, 1'b0);
        expect_state("back_to_5", 5, 1'b0, 1'b0);
        vehicle(2'b01, 2'b01, 1'b0, 1'b0);
        expect_state("same_lane_net", 5, 1'b0, 1'b0);

        vehicle(2'b00, 2'b11, 1'b0, 1'b0);
        vehicle(2'b00, 2'b11, 1'b0, 1'b0);
        expect_state("down_to_1", 1, 1'b0, 1'b0);
        vehicle(2'b00, 2'b11, 1'b0, 1'b0);
        expect_state("underflow_clip", 0, 1'b0, 1'b1);
        vehicle(2'b00, 2'b11, 1'b1, 1'b0);
        expect_state("underflow_beats_clear", 0, 1'b0, 1'b1);

        for (int i = 0; i < 6; i++) vehicle(2'b11, 2'b00, 1'b0, 1'b0);
        expect_state("up_to_12", 12, 1'b0, 1'b1);
        vehicle(2'b01, 2'b00, 1'b0, 1'b1);
        expect_state("preset_discards_pulse", 0, 1'b0, 1'b1);
        clear_err = 1'b1;
        idle(1);
        clear_err = 1'b0;
        expect_state("clear_underflow", 0, 1'b0, 1'b0);

        vehicle(2'b01, 2'b00, 1'b0, 1'b0);
        vehicle(2'b01, 2'b00, 1'b0, 1'b0);
        vehicle(2'b00, 2'b00, 1'b1, 1'b0);
        expect_state("before_midreset", 2, 1'b0, 1'b0);
        // Mid-event reset: enter[1] rises and is captured, then reset hits.
        enter = 2'b10;
        idle(1);
        #1 reset_n = 1'b0;
        expect_state("midreset_async", 0, 1'b0, 1'b0);
        idle(2);
        reset_n = 1'b1;
        idle(5);
        expect_state("after_midreset_held", 0, 1'b0, 1'b0);
        enter = 2'b00;
        idle(4);
        expect_state("after_midreset_low", 0, 1'b0, 1'b0);
        vehicle(2'b10, 2'b00, 1'b0, 1'b0);
        expect_state("resume_counting", 1, 1'b0, 1'b0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        idle(1);
        if (q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
